// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared memory port, stalling on mem_ready.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes enter TRAP and redirect
// the PC to TRAP_VECTOR. Without it they retire as a NOP.
module multicycle_ctrl #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t cur_state, nxt_state;

  // The vector value itself is applied by the datapath PC mux (PCSource=11);
  // the controller only selects it.
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;

  assign state = cur_state;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  // Next-state and control decode; everything held at zero during reset.
  always_comb begin
    nxt_state   = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    if (rst_n) begin
      case (cur_state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          nxt_state = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_LW, OP_SW: nxt_state = MEMADR;
            OP_RTYP:      nxt_state = EXEC;
            OP_BEQ:       nxt_state = BRANCH;
            OP_J:         nxt_state = JUMP;
            OP_ADDI:      nxt_state = ADDIEX;
`ifdef ILLEGAL_TRAP_EN
            default:      nxt_state = TRAP;
`else
            default:      nxt_state = FETCH;
`endif
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt_state = (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          nxt_state = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          nxt_state = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          nxt_state = RWB;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          nxt_state = ADDIWB;
        end
        ADDIWB: begin
          RegWrite = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          illegal_op = 1'b1;
          PCWrite    = 1'b1;
          PCSource   = 2'b11;
        end
`endif
        default: nxt_state = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model
// (per-opcode step lists with memory waits) checked every cycle, plus
// directed instruction traces and randomized instruction streams.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  multicycle_ctrl #(.TRAP_VECTOR(32'h0000_0080)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic ill;
  } ctrl_t;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int         seq[$];
  int         idx = 0;
  bit         done = 0;
  logic [5:0] cur_op = 6'd0;
  int         trace[$];
  int         mw_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.pcw = PCWrite; c.pcwc = PCWriteCond; c.iord = IorD; c.mrd = MemRead;
    c.mwr = MemWrite; c.irw = IRWrite; c.m2r = MemtoReg; c.rdst = RegDst;
    c.rw = RegWrite; c.srca = ALUSrcA; c.srcb = ALUSrcB; c.aluop = ALUOp;
    c.pcsrc = PCSource; c.ill = illegal_op;
    return c;
  endfunction

  // Control values each spec step must present
  function automatic ctrl_t spec_ctrl(input int code, input logic mr);
    ctrl_t c = '0;
    case (code)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = 2'b10; end
      7:  begin c.rw = 1; c.rdst = 1; end
      8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
      10: begin c.srca = 1; c.srcb = 2'b10; end
      11: c.rw = 1;
      12: begin c.ill = 1; c.pcw = 1; c.pcsrc = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Step list of an instruction, as spec state codes
  function automatic void build_seq(input logic [5:0] op);
    seq = '{0, 1};
    case (op)
      6'b100011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      6'b101011: begin seq.push_back(2); seq.push_back(5); end
      6'b000000: begin seq.push_back(6); seq.push_back(7); end
      6'b000100: seq.push_back(8);
      6'b000010: seq.push_back(9);
      6'b001000: begin seq.push_back(10); seq.push_back(11); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        seq.push_back(12);
`endif
      end
    endcase
  endfunction

  function automatic bit is_mem_wait(input int code);
    return (code == 0) || (code == 3) || (code == 5);
  endfunction

  task automatic cycle(input logic mr, input logic z);
    int code;
    @(negedge clk);
    opcode = cur_op; mem_ready = mr; zero = z;
    #1;
    code = seq[idx];
    chk("state", 32'(state), 32'(code));
    chk("ctrl", 32'(dut_ctrl()), 32'(spec_ctrl(code, mr)));
    chk("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
    chk("rw_mw_excl", 32'(RegWrite & MemWrite), 32'd0);
    trace.push_back(int'(state));
    if (MemWrite) mw_cnt++;
    @(posedge clk);
    #1;
    if (!(is_mem_wait(code) && !mr)) idx++;
    if (idx >= seq.size()) begin idx = 0; done = 1; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(dut_ctrl()), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_state", 32'(state), 32'd0);
    chk("rst_hold_ctrl", 32'(dut_ctrl()), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    idx = 0;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input bit rand_mr,
                           input int sw_waits, input logic [31:0] exp_seq, input int n);
    int waits = sw_waits;
    int cyc = 0;
    logic mr;
    cur_op = op; build_seq(op); idx = 0; done = 0; trace.delete(); mw_cnt = 0;
    while (!done && cyc < 64) begin
      mr = rand_mr ? logic'($urandom_range(0, 2) != 0) : 1'b1;
      if (seq[idx] == 5 && waits > 0) begin mr = 1'b0; waits--; end
      cycle(mr, z);
      cyc++;
    end
    chk("instr_done", 32'(done), 32'd1);
    if (!done) do_reset();
    if (n > 0) begin
      chk("seq_len", 32'(trace.size()), 32'(n));
      for (int i = 0; i < n && i < trace.size(); i++)
        chk("seq_state", 32'(trace[i]), 32'(exp_seq[4*(n-1-i) +: 4]));
    end
  endtask

  logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

  function automatic logic [5:0] pick_illegal();
    logic [5:0] o;
    bit legal;
    do begin
      o = 6'($urandom_range(0, 63));
      legal = 0;
      foreach (ops[k]) if (ops[k] == o) legal = 1;
    end while (legal);
    return o;
  endfunction

  initial begin
    #1;
    chk("por_state", 32'(state), 32'd0);
    chk("por_ctrl", 32'(dut_ctrl()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lw, sw with 3 wait cycles, beq both ways, R-type, addi, j
    run_instr(6'b100011, 1'b0, 0, 0, {12'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);
    run_instr(6'b101011, 1'b0, 0, 3, {4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5}, 7);
    chk("sw_memwrite_cycles", 32'(mw_cnt), 32'd4);
    run_instr(6'b101011, 1'b0, 0, 0, {16'd0, 4'd0, 4'd1, 4'd2, 4'd5}, 4);
    run_instr(6'b000100, 1'b1, 0, 0, {20'd0, 4'd0, 4'd1, 4'd8}, 3);
    run_instr(6'b000100, 1'b0, 0, 0, {20'd0, 4'd0, 4'd1, 4'd8}, 3);
    run_instr(6'b000000, 1'b0, 0, 0, {16'd0, 4'd0, 4'd1, 4'd6, 4'd7}, 4);
    run_instr(6'b001000, 1'b0, 0, 0, {16'd0, 4'd0, 4'd1, 4'd10, 4'd11}, 4);
    run_instr(6'b000010, 1'b0, 0, 0, {20'd0, 4'd0, 4'd1, 4'd9}, 3);
`ifdef ILLEGAL_TRAP_EN
    run_instr(6'b111111, 1'b0, 0, 0, {20'd0, 4'd0, 4'd1, 4'd12}, 3);
`else
    run_instr(6'b111111, 1'b0, 0, 0, {24'd0, 4'd0, 4'd1}, 2);
`endif

    // reset while waiting in MEMRD, then a clean lw
    cur_op = 6'b100011; build_seq(cur_op); idx = 0; done = 0;
    for (int k = 0; k < 8 && seq[idx] != 3; k++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    do_reset();
    run_instr(6'b100011, 1'b0, 0, 0, {12'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 5);

    // randomized instruction stream with random memory latency
    for (int r = 0; r < 200; r++) begin
      int sel = int'($urandom_range(0, 6));
      logic [5:0] op = (sel == 6) ? pick_illegal() : ops[sel];
      run_instr(op, logic'($urandom_range(0, 1)), 1, 0, 32'd0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
